// File: rtl/fetch_decode_stage.sv
// Multi-cycle fetch/decode stage: FETCH -> LOAD -> EXEC -> WRITE per instruction,
// latching the fetched word and driving a registered control bundle to execute.
module fetch_decode_stage #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instruction,
  output logic                aluSrcb,
  output logic                shiftSrc,
  output logic                memSrc,
  output logic                regWriteEn,
  output logic                RaWriteEn,
  output logic [2:0]          aluop,
  output logic                shifttype,
  output logic                halted
);

  typedef enum logic [2:0] {StFetch, StLoad, StExec, StWrite, StHalt} state_e;

  localparam logic [PC_WIDTH-1:0] ResetPc = RESET_PC[PC_WIDTH-1:0];

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                alu_src_b_q, alu_src_b_d;
  logic                shift_src_q, shift_src_d;
  logic                mem_src_q, mem_src_d;
  logic                reg_we_q, reg_we_d;
  logic [2:0]          aluop_q, aluop_d;
  logic                shift_type_q, shift_type_d;
  logic                halted_q, halted_d;

  // Combinational decode of the word arriving from memory.
  logic       dec_alu_src_b, dec_shift_src, dec_mem_src, dec_shift_type;
  logic [2:0] dec_aluop;
  logic [3:0] opcode, func;

  assign opcode = imem_rdata[31:28];
  assign func   = imem_rdata[3:0];

  always_comb begin
    dec_alu_src_b  = 1'b0;
    dec_shift_src  = 1'b0;
    dec_mem_src    = 1'b0;
    dec_shift_type = 1'b0;
    dec_aluop      = 3'd0;
    unique case (opcode)
      4'b0000: begin
        dec_alu_src_b = 1'b1;
        dec_mem_src   = 1'b1;
        unique case (func)
          4'b0101: dec_aluop = 3'd0;
          4'b1001: dec_aluop = 3'd1;
          4'b0001: dec_aluop = 3'd2;
          4'b0010: dec_aluop = 3'd3;
          4'b0011: dec_aluop = 3'd4;
          default: begin
            // Unlisted func is a NOP: nothing asserted.
            dec_alu_src_b = 1'b0;
            dec_mem_src   = 1'b0;
          end
        endcase
      end
      4'b0101: begin dec_mem_src = 1'b1; dec_aluop = 3'd0; end
      4'b1001: begin dec_mem_src = 1'b1; dec_aluop = 3'd1; end
      4'b0001: begin dec_mem_src = 1'b1; dec_aluop = 3'd2; end
      4'b0010: begin dec_mem_src = 1'b1; dec_aluop = 3'd3; end
      4'b0011: begin dec_mem_src = 1'b1; dec_aluop = 3'd4; end
      4'b1000: begin
        dec_mem_src    = 1'b1;
        dec_shift_src  = 1'b1;
        dec_shift_type = imem_rdata[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    alu_src_b_d  = alu_src_b_q;
    shift_src_d  = shift_src_q;
    mem_src_d    = mem_src_q;
    reg_we_d     = 1'b0;
    aluop_d      = aluop_q;
    shift_type_d = shift_type_q;
    halted_d     = halted_q;
    unique case (state_q)
      StFetch: begin
        if (!stall) state_d = StLoad;
      end
      StLoad: begin
        instr_d      = imem_rdata;
        alu_src_b_d  = dec_alu_src_b;
        shift_src_d  = dec_shift_src;
        mem_src_d    = dec_mem_src;
        aluop_d      = dec_aluop;
        shift_type_d = dec_shift_type;
        if (opcode == 4'b1111) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // memSrc doubles as the "instruction writes" flag.
        reg_we_d = mem_src_q;
        state_d  = StWrite;
      end
      StWrite: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = StFetch;
      end
      StHalt: begin
        alu_src_b_d  = 1'b0;
        shift_src_d  = 1'b0;
        mem_src_d    = 1'b0;
        aluop_d      = 3'd0;
        shift_type_d = 1'b0;
        halted_d     = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= ResetPc;
      instr_q      <= 32'd0;
      alu_src_b_q  <= 1'b0;
      shift_src_q  <= 1'b0;
      mem_src_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      aluop_q      <= 3'd0;
      shift_type_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      alu_src_b_q  <= alu_src_b_d;
      shift_src_q  <= shift_src_d;
      mem_src_q    <= mem_src_d;
      reg_we_q     <= reg_we_d;
      aluop_q      <= aluop_d;
      shift_type_q <= shift_type_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign aluSrcb     = alu_src_b_q;
  assign shiftSrc    = shift_src_q;
  assign memSrc      = mem_src_q;
  assign regWriteEn  = reg_we_q;
  assign RaWriteEn   = 1'b0;
  assign aluop       = aluop_q;
  assign shifttype   = shift_type_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: decode table vectors, stall, halt,
// mid-write reset, and pc wrap on a 2-bit PC instance fed all-zero words.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] imem_rdata;
  logic [7:0]  imem_addr, pc;
  logic [31:0] instruction;
  logic        aluSrcb, shiftSrc, memSrc, regWriteEn, RaWriteEn, shifttype, halted;
  logic [2:0]  aluop;

  logic [1:0]  addr2, pc2;
  logic [31:0] instr2;
  logic        asb2, ss2, ms2, rwe2, ra2, st2, halted2;
  logic [2:0]  aluop2;

  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  fetch_decode_stage #(.PC_WIDTH(8), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc(pc), .instruction(instruction), .aluSrcb(aluSrcb),
    .shiftSrc(shiftSrc), .memSrc(memSrc), .regWriteEn(regWriteEn), .RaWriteEn(RaWriteEn),
    .aluop(aluop), .shifttype(shifttype), .halted(halted)
  );

  fetch_decode_stage #(.PC_WIDTH(2), .RESET_PC(0)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .imem_rdata(32'h0),
    .imem_addr(addr2), .pc(pc2), .instruction(instr2), .aluSrcb(asb2),
    .shiftSrc(ss2), .memSrc(ms2), .regWriteEn(rwe2), .RaWriteEn(ra2),
    .aluop(aluop2), .shifttype(st2), .halted(halted2)
  );

  typedef struct {
    logic [31:0] instr;
    logic        asb;
    logic        ss;
    logic        ms;
    logic [2:0]  op;
    logic        st;
    logic        wr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h50800004, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[1]  = '{32'h0184A005, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[2]  = '{32'h0184A009, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1};
    vecs[3]  = '{32'h00000001, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1};
    vecs[4]  = '{32'h00000002, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1};
    vecs[5]  = '{32'h00000003, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
    vecs[6]  = '{32'h90000000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1};
    vecs[7]  = '{32'h10000000, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1};
    vecs[8]  = '{32'h20000000, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1};
    vecs[9]  = '{32'h30000000, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
    vecs[10] = '{32'h80000001, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1};
    vecs[11] = '{32'h80000000, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[12] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{32'h0000000F, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{32'h70000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[15] = '{32'h40000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    for (int a = 0; a < 16; a++) mem[a] = vecs[a].instr;
    mem[16] = 32'h50800004;
    mem[17] = 32'hF0000000;

    reset = 1'b1;
    stall = 1'b0;
    step();
    step();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_we", 32'(regWriteEn), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ctrl", {27'd0, aluSrcb, shiftSrc, memSrc, shifttype, aluop != 3'd0}, 32'd0);
    reset = 1'b0;

    // Decode table: one 4-cycle instruction per vector, straight-line memory.
    for (int i = 0; i < 16; i++) begin
      chk("vec_pc_start", 32'(pc), 32'(i));
      chk("vec_addr", 32'(imem_addr), 32'(i));
      step();
      chk("vec_we_load", 32'(regWriteEn), 32'd0);
      chk("pc2_we", 32'(rwe2), 32'd0);
      step();
      chk("vec_instr", instruction, vecs[i].instr);
      chk("vec_aluSrcb", 32'(aluSrcb), 32'(vecs[i].asb));
      chk("vec_shiftSrc", 32'(shiftSrc), 32'(vecs[i].ss));
      chk("vec_memSrc", 32'(memSrc), 32'(vecs[i].ms));
      chk("vec_aluop", 32'(aluop), 32'(vecs[i].op));
      chk("vec_shifttype", 32'(shifttype), 32'(vecs[i].st));
      chk("vec_we_exec", 32'(regWriteEn), 32'd0);
      chk("vec_ra", 32'(RaWriteEn), 32'd0);
      chk("vec_halted", 32'(halted), 32'd0);
      chk("pc2_we", 32'(rwe2), 32'd0);
      step();
      chk("vec_we_write", 32'(regWriteEn), 32'(vecs[i].wr));
      chk("vec_pc_hold", 32'(pc), 32'(i));
      chk("pc2_we", 32'(rwe2), 32'd0);
      step();
      chk("vec_we_after", 32'(regWriteEn), 32'd0);
      chk("vec_pc_next", 32'(pc), 32'(i + 1));
      chk("pc2_wrap", 32'(pc2), 32'((i + 1) % 4));
      chk("pc2_we", 32'(rwe2), 32'd0);
    end

    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_pc", 32'(pc), 32'd16);
      chk("stall_addr", 32'(imem_addr), 32'd16);
      chk("stall_we", 32'(regWriteEn), 32'd0);
    end
    stall = 1'b0;
    step();
    step();
    chk("unstall_instr", instruction, 32'h50800004);
    step();
    chk("unstall_we", 32'(regWriteEn), 32'd1);
    step();
    chk("unstall_we_off", 32'(regWriteEn), 32'd0);
    chk("unstall_pc", 32'(pc), 32'd17);

    step();
    chk("halt_early", 32'(halted), 32'd0);
    step();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_ctrl", {29'd0, aluSrcb, shiftSrc, memSrc}, 32'd0);
    for (int c = 0; c < 22; c++) begin
      step();
      chk("halt_pc", 32'(pc), 32'd17);
      chk("halt_we", 32'(regWriteEn), 32'd0);
      chk("halt_hold", 32'(halted), 32'd1);
    end

    reset = 1'b1;
    #1;
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_pc", 32'(pc), 32'd0);
    mem[0] = 32'h80000001;
    step();
    reset = 1'b0;

    step();
    step();
    chk("shift_instr", instruction, 32'h80000001);
    chk("shift_src", 32'(shiftSrc), 32'd1);
    chk("shift_type", 32'(shifttype), 32'd1);
    step();
    chk("shift_we", 32'(regWriteEn), 32'd1);
    // Async reset while in WRITE, well away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(regWriteEn), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_shift", 32'(shiftSrc), 32'd0);
    chk("midrst_instr", instruction, 32'd0);
    step();
    chk("midrst_pc_edge", 32'(pc), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("restart_instr", instruction, 32'h80000001);
    step();
    chk("restart_we", 32'(regWriteEn), 32'd1);
    step();
    chk("restart_pc", 32'(pc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
Multi-cycle instruction fetch and decode stage that sits directly upstream of the execution stage. It owns the PC and reads a synchronous instruction memory. It latches the fetched word and drives the registered `instruction`/control bundle the execution stage consumes (aluSrcb, shiftSrc, memSrc, regWriteEn, RaWriteEn, aluop, shifttype). Each instruction takes a fixed 4-state sequence; there is no pipelining.

Parameters:
PC_WIDTH, 8, width of PC and imem_addr
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold request, sampled only in FETCH
imem_rdata  in  32  instruction memory read data, valid one cycle after imem_addr
imem_addr  out  PC_WIDTH  instruction memory address, always equals pc
pc  out  PC_WIDTH  current program counter
instruction  out  32  latched instruction word
aluSrcb  out  1  1 = Rt operand, 0 = immediate
shiftSrc  out  1  1 = shifter result selected
memSrc  out  1  1 = ALU/shift result written back to Rdest
regWriteEn  out  1  register file write strobe
RaWriteEn  out  1  reserved, tied 0
aluop  out  3  ALU operation code
shifttype  out  1  0 = left, 1 = right
halted  out  1  HALT executed

Behaviour:
- Instruction fields: opcode [31:28], Rdest [27:23], Rsrc [22:18], Rt [17:13], imm [17:0], func [3:0].
- All outputs are registered.
- Reset (async) sets the following, regardless of state:
  - state = FETCH, pc = RESET_PC
  - instruction = 0, all control outputs = 0, halted = 0
- FSM states: FETCH, LOAD, EXEC, WRITE, HALT.
- FETCH:
  - imem_addr = pc.
  - If stall = 1, stay in FETCH. Otherwise go to LOAD.
- LOAD:
  - Latch instruction <= imem_rdata and register the decoded controls in the same edge.
  - regWriteEn stays 0.
  - Opcode 1111 goes to HALT; all other opcodes go to EXEC.
- EXEC:
  - Controls are held stable so the execution stage can compute; regWriteEn = 0.
  - Next state is WRITE.
  - regWriteEn is set to 1 on the EXEC->WRITE edge only if the decoded instruction writes.
- WRITE:
  - regWriteEn is high for exactly this one cycle.
  - On exit: regWriteEn <= 0, pc <= pc + 1, next state is FETCH.
- Latency:
  - 4 cycles per instruction when not stalled.
  - First regWriteEn is high between the 3rd and 4th rising edges after reset release.
- Decode table (memSrc = 1 whenever the instruction writes):
  - opcode 0000, R-type, aluSrcb = 1, shiftSrc = 0; aluop by func: 0101 ADD = 0, 1001 SUB = 1, 0001 AND = 2, 0010 OR = 3, 0011 XOR = 4.
  - opcodes 0101 / 1001 / 0001 / 0010 / 0011: immediate forms, aluSrcb = 0, aluop = 0 / 1 / 2 / 3 / 4 respectively.
  - opcode 1000, SHIFT: shiftSrc = 1, aluSrcb = 0, shifttype = instruction[0].
  - Any other opcode, or R-type with an unlisted func: NOP. All controls = 0, regWriteEn never asserts, pc still increments.
- Instruction word 0 decodes as NOP.
- HALT: halted = 1, controls = 0, pc frozen. Terminal state; only reset exits.
- pc wraps from 2^PC_WIDTH-1 to 0 with no flag.
- stall is ignored in LOAD, EXEC and WRITE, so an instruction in flight always completes.
- Reset asserted mid-instruction (any state): outputs drop immediately without waiting for clk, and the in-flight write is lost.
- RaWriteEn is always 0.

Test Plan:
- Reset, imem[0] = 0x50800004 (addi R1,R0,4) -> instruction = 0x50800004, aluSrcb = 0, aluop = 0, memSrc = 1 after edge 2; regWriteEn high only between edges 3 and 4; pc = 1 after edge 4.
- imem[1] = 0x0184A005 (add R3,R1,R5) -> aluSrcb = 1, aluop = 0, memSrc = 1, one regWriteEn pulse, pc 1 -> 2; then imem[2] = 0x0184A009 (SUB) -> aluop = 1.
- stall = 1 for 5 cycles in FETCH -> pc and imem_addr frozen, regWriteEn = 0 throughout; release -> normal 4-cycle completion.
- imem[k] = 0xF0000000 -> halted = 1 one edge after LOAD, regWriteEn never asserts, pc stays k for 20+ cycles; reset -> halted = 0, pc = 0.
- PC_WIDTH = 2 with four NOPs (0x0) -> pc sequence 1, 2, 3, 0, regWriteEn never high.
- SHIFT 0x80000001 -> shiftSrc = 1, shifttype = 1. Assert reset mid-WRITE (asynchronously, between edges) -> regWriteEn drops to 0 before next edge, pc = 0, state FETCH.
